// File: rtl/mesm6_uart_tx.sv
// mesm6_uart_tx: memory-mapped serial transmitter with a byte FIFO on the mesm6 data bus.
// Sends 8N1 frames LSB first and raises a level interrupt when the FIFO drains.
// Optional build macro MESM6_UART_TX_PARITY_EN adds an even-parity bit (8E1) via CONTROL bit2.
module mesm6_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd86
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_int,
  input  logic [14:0] i_addr,
  input  logic        i_read,
  input  logic        i_write,
  output logic [47:0] o_rdata,
  input  logic [47:0] i_wdata,
  output logic        o_done,
  output logic        o_txd
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MESM6_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   divisor_q, cnt_q;
  logic [2:0]    ctrl_q, bit_q;
  logic          ovf_q, done_q, int_q, txd_q;
  logic [47:0]   rdata_q;
  logic [7:0]    shreg_q;
`ifdef MESM6_UART_TX_PARITY_EN
  logic          par_q;
`endif
  logic          acc, wr_acc, rd_acc, full, empty, push, pop, bit_end, txd_d, ctrl_par;
  logic [15:0]   status, rd_mux;
  logic          unused_bits;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // A request is only taken when no completion pulse is showing, so a held request
  // alternates accept / ignore.
  assign acc      = (i_read | i_write) & ~done_q;
  assign wr_acc   = acc & i_write;
  assign rd_acc   = acc & i_read & ~i_write;
  assign push     = wr_acc & (i_addr[1:0] == 2'd0) & ~full;
  assign bit_end  = (cnt_q == 16'd0);
  assign unused_bits = ^{i_addr[14:2], i_wdata[47:16], i_wdata[2]};

`ifdef MESM6_UART_TX_PARITY_EN
  assign ctrl_par = i_wdata[2];
`else
  assign ctrl_par = 1'b0;
`endif

  // Register read multiplexer; STATUS snapshot is taken before this cycle's updates.
  always_comb begin
    status       = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = (state_q != S_IDLE);
    status[3]    = ovf_q;
    status[15:8] = 8'(count_q);
    rd_mux       = '0;
    unique case (i_addr[1:0])
      2'd0: rd_mux = '0;
      2'd1: rd_mux = status;
      2'd2: rd_mux = divisor_q;
      2'd3: rd_mux = {13'd0, ctrl_q};
    endcase
  end

  // Bus responder: completion pulse, read data, DIVISOR/CONTROL writes, overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      rdata_q   <= '0;
      divisor_q <= DIV_RESET;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= acc;
      if (wr_acc) begin
        unique case (i_addr[1:0])
          2'd0: if (full) ovf_q <= 1'b1;
          2'd2: divisor_q <= i_wdata[15:0];
          2'd3: ctrl_q <= {ctrl_par, i_wdata[1:0]};
          default: ;
        endcase
      end else if (rd_acc) begin
        rdata_q <= {32'd0, rd_mux};
        if (i_addr[1:0] == 2'd1) ovf_q <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_wdata[7:0];
  end

  // Frame sequencer: next state, pop request and line value for the current bit.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_q[0] && !empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shreg_q[0];
        if (bit_end && (bit_q == 3'd7)) begin
`ifdef MESM6_UART_TX_PARITY_EN
          state_d = ctrl_q[2] ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef MESM6_UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (ctrl_q[0] && !empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, bit-time counter, bit index, registered line and interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      int_q   <= ctrl_q[1] & empty & (state_q == S_IDLE);
      if (pop) begin
        cnt_q <= divisor_q;
        bit_q <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? divisor_q : cnt_q - 16'd1;
        if ((state_q == S_DATA) && bit_end) bit_q <= bit_q + 3'd1;
      end
    end
  end

  // Shift register loaded on pop, shifted right at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg_q <= fifo_mem[rd_ptr_q];
`ifdef MESM6_UART_TX_PARITY_EN
      par_q   <= ^fifo_mem[rd_ptr_q];
`endif
    end else if ((state_q == S_DATA) && bit_end) begin
      shreg_q <= {1'b0, shreg_q[7:1]};
    end
  end

  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_int   = int_q;
  assign o_txd   = txd_q;

endmodule

// File: tb/tb_mesm6_uart_tx.sv
// tb_mesm6_uart_tx: bench for mesm6_uart_tx with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mesm6_uart_tx;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd86;
`ifdef MESM6_UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read = 1'b0, i_write = 1'b0;
  logic [14:0] i_addr = '0;
  logic [47:0] i_wdata = '0;
  logic [47:0] o_rdata;
  logic        o_int, o_done, o_txd;

  int n_cmp = 0;
  int n_fail = 0;

  mesm6_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk(clk), .reset(rst_n), .o_int(o_int), .i_addr(i_addr), .i_read(i_read),
    .i_write(i_write), .o_rdata(o_rdata), .i_wdata(i_wdata), .o_done(o_done), .o_txd(o_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, register values, and the future line waveform as a
  // queue of per-clock samples.
  byte unsigned mq[$];
  bit           lq[$];
  logic [15:0]  m_div = DIVR;
  logic [2:0]   m_ctrl = '0;
  logic         m_ovf = 1'b0, m_done = 1'b0, m_int = 1'b0, m_txd = 1'b1;
  logic [47:0]  m_rdata = '0;

  task automatic model_step();
    int           cnt    = mq.size();
    bit           acc    = (i_read || i_write) && !m_done;
    bit           busy   = (lq.size() >= 1);
    bit           dopop  = (lq.size() <= 1) && m_ctrl[0] && (cnt > 0);
    bit           nint   = m_ctrl[1] && (cnt == 0) && !busy;
    logic [2:0]   ctrl_at = m_ctrl;
    logic [15:0]  div_at  = m_div;
    logic [15:0]  st;
    byte unsigned b = 0;
    bit           fb[$];
    if (dopop) b = mq.pop_front();
    if (acc && i_write) begin
      case (i_addr[1:0])
        2'd0: if (cnt < DEPTH) mq.push_back(i_wdata[7:0]); else m_ovf = 1'b1;
        2'd2: m_div = i_wdata[15:0];
        2'd3: m_ctrl = {HAS_PAR ? i_wdata[2] : 1'b0, i_wdata[1:0]};
        default: ;
      endcase
    end else if (acc && i_read) begin
      st = {8'(cnt), 4'd0, m_ovf, busy, (cnt == 0), (cnt == DEPTH)};
      case (i_addr[1:0])
        2'd0: m_rdata = '0;
        2'd1: m_rdata = {32'd0, st};
        2'd2: m_rdata = {32'd0, div_at};
        default: m_rdata = {45'd0, ctrl_at};
      endcase
      if (i_addr[1:0] == 2'd1) m_ovf = 1'b0;
    end
    m_txd = (lq.size() > 0) ? lq.pop_front() : 1'b1;
    if (dopop) begin
      fb.push_back(1'b0);
      for (int k = 0; k < 8; k++) fb.push_back(b[k]);
      if (HAS_PAR && ctrl_at[2]) fb.push_back(^b);
      fb.push_back(1'b1);
      foreach (fb[k]) repeat (int'(div_at) + 1) lq.push_back(fb[k]);
    end
    m_done = acc;
    m_int  = nint;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); lq.delete();
      m_div = DIVR; m_ctrl = '0; m_ovf = 1'b0; m_done = 1'b0;
      m_int = 1'b0; m_txd = 1'b1; m_rdata = '0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    check("txd",   48'(o_txd),  48'(m_txd));
    check("done",  48'(o_done), 48'(m_done));
    check("int",   48'(o_int),  48'(m_int));
    check("rdata", o_rdata,     m_rdata);
  end

  task automatic bus_op(input bit rd, input bit wr, input logic [1:0] a,
                        input logic [47:0] d, input int hold);
    @(negedge clk);
    i_read = rd; i_write = wr; i_addr = {13'd0, a}; i_wdata = d;
    repeat (hold) @(negedge clk);
    i_read = 1'b0; i_write = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [47:0] d);
    bus_op(1'b0, 1'b1, a, d, 1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [47:0] d);
    @(negedge clk);
    i_read = 1'b1; i_addr = {13'd0, a};
    @(negedge clk);
    d = o_rdata;
    i_read = 1'b0;
  endtask

  task automatic wait_fall(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (o_txd == 1'b0) break;
      @(negedge clk);
    end
    check(name, 48'(i < limit), 48'd1);
  endtask

  task automatic wait_drain(input logic [2:0] keep);
    int i;
    bus_write(2'd3, {45'd0, keep[2], 1'b0, 1'b1});
    for (i = 0; i < 20000; i++) begin
      if (mq.size() == 0 && lq.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", 48'(i < 20000), 48'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    logic [9:0]  pat;
    logic [40:0] got41, exp41;
    logic [11:0] got12, exp12;
    logic [5:0]  dn;
    int          lows, falls, last_rise, ihigh;
    bit          prev;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of the register map and outputs.
    bus_read(2'd0, d); check("rst_data", d, 48'h0);
    bus_read(2'd1, d); check("rst_status", d, 48'h0002);
    bus_read(2'd2, d); check("rst_divisor", d, 48'd86);
    bus_read(2'd3, d); check("rst_control", d, 48'h0);
    check("rst_txd", 48'(o_txd), 48'd1);
    check("rst_int", 48'(o_int), 48'd0);

    // Single 0x55 frame at 4 clocks per bit.
    bus_write(2'd2, 48'd3);
    bus_write(2'd3, 48'd1);
    bus_write(2'd0, 48'h55);
    check("done_pulse", 48'(o_done), 48'd1);
    @(negedge clk); check("txd_before_start", 48'(o_txd), 48'd1);
    @(negedge clk);
    lows = 0;
    for (int i = 0; i < 41; i++) begin
      got41[i] = o_txd;
      if (!o_txd) lows++;
      @(negedge clk);
    end
    pat = 10'b1010101010;
    exp41[40] = 1'b1;
    for (int i = 0; i < 40; i++) exp41[i] = pat[i / 4];
    check("frame55", 48'(got41), 48'(exp41));
    check("frame55_lows", 48'(lows), 48'd20);

    // Overflow with transmitter disabled, then eight back-to-back frames of 0x00.
    bus_write(2'd3, 48'd0);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 48'h00);
    bus_read(2'd1, d); check("status_full_ovf", d, 48'h0809);
    bus_read(2'd1, d); check("status_ovf_clear", d, 48'h0801);
    bus_write(2'd3, 48'd1);
    wait_fall("b2b_first_fall", 10);
    falls = 1; last_rise = -1; prev = 1'b0;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (prev && !o_txd) falls++;
      if (!prev && o_txd) last_rise = i;
      prev = o_txd;
    end
    check("b2b_frames", 48'(falls), 48'd8);
    check("b2b_last_rise", 48'(last_rise), 48'd316);

    // Interrupt: set while idle and empty, dropped by a DATA write, back after STOP.
    bus_write(2'd3, 48'd3);
    bus_write(2'd0, 48'hA5);
    check("int_idle", 48'(o_int), 48'd1);
    @(negedge clk); check("int_drop", 48'(o_int), 48'd0);
    wait_fall("int_frame_fall", 10);
    ihigh = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_int) ihigh++;
      @(negedge clk);
    end
    check("int_during_frame", 48'(ihigh), 48'd0);
    check("int_after_stop", 48'(o_int), 48'd1);

    // Held read: one access per two cycles of hold.
    @(negedge clk);
    i_read = 1'b1; i_addr = 15'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dn[i] = o_done;
    end
    i_read = 1'b0;
    check("held_read_done", 48'(dn), 48'(6'b010101));

    // Asynchronous reset in the middle of a frame.
    bus_write(2'd3, 48'd1);
    bus_write(2'd0, 48'h00);
    bus_write(2'd0, 48'h00);
    repeat (10) @(negedge clk);
    check("txd_mid_frame", 48'(o_txd), 48'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("txd_async_reset", 48'(o_txd), 48'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'd1, d); check("status_after_reset", d, 48'h0002);

    // Parity option: two queued bytes at 1 clock per bit expose the frame length.
    bus_write(2'd2, 48'd0);
    bus_write(2'd0, 48'h07);
    bus_write(2'd0, 48'h00);
    bus_write(2'd3, 48'd5);
    wait_fall("par_fall", 10);
    for (int i = 0; i < 12; i++) begin
      got12[i] = o_txd;
      @(negedge clk);
    end
`ifdef MESM6_UART_TX_PARITY_EN
    exp12 = 12'b011000001110;
    bus_read(2'd3, d); check("par_ctrl", d, 48'd5);
`else
    exp12 = 12'b001000001110;
    bus_read(2'd3, d); check("par_ctrl", d, 48'd1);
`endif
    check("par_frame", 48'(got12), 48'(exp12));
    wait_drain(3'd1);

    // Randomised traffic checked cycle by cycle against the model.
    for (int r = 0; r < 6; r++) begin
      logic [2:0] ctl;
      bit         par;
      par = HAS_PAR ? 1'($urandom_range(0, 1)) : 1'b0;
      wait_drain({par, 2'b01});
      bus_write(2'd2, 48'($urandom_range(0, 2)));
      ctl = {par, 1'($urandom_range(0, 1)), 1'b1};
      bus_write(2'd3, 48'(ctl));
      for (int k = 0; k < 40; k++) begin
        int op;
        op = $urandom_range(0, 9);
        if (op <= 4)      bus_op(1'b0, 1'b1, 2'd0, 48'($urandom_range(0, 255)), $urandom_range(1, 3));
        else if (op <= 6) bus_op(1'b1, 1'b0, 2'($urandom_range(0, 3)), 48'd0, $urandom_range(1, 3));
        else if (op == 7) bus_op(1'b1, 1'b1, 2'd0, 48'($urandom_range(0, 255)), 1);
        else if (op == 8) bus_op(1'b0, 1'b1, 2'd3,
                                 {45'd0, par, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))}, 1);
        else              repeat ($urandom_range(1, 30)) @(negedge clk);
      end
      wait_drain({par, 2'b01});
      bus_read(2'd1, d);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mesm6_uart_tx.md
Name: mesm6_uart_tx

Overview:
- Memory-mapped serial transmitter on the mesm6 data bus, behind a mesm6_mmu peripheral port, alongside the pic and gpio.
- Acts as the bus responder: it serves the core's read and write requests and sends 8N1 asynchronous serial frames from a byte FIFO.
- Raises an interrupt toward mesm6_pic when the FIFO drains.

Parameters:
FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2
DIV_RESET, 16'd86, DIVISOR value after reset (bit time = DIVISOR+1 clocks)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset; block held in reset while low
o_int  output  1  interrupt request to the pic, level
i_addr  input  15  word address; only i_addr[1:0] decoded
i_read  input  1  read request
i_write  input  1  write request
o_rdata  output  48  register read data; zero-extended
i_wdata  input  48  write data
o_done  output  1  operation completed, one-cycle pulse
o_txd  output  1  serial line; idle high

Behaviour:
- Reset values: o_int=0, o_done=0, o_rdata=0, o_txd=1, FIFO empty, DIVISOR=DIV_RESET, CONTROL=0, overflow=0, FSM=IDLE.
- Reset asserted mid-frame: o_txd goes to 1 immediately (asynchronous) and the frame is lost.
- Register map (i_addr[1:0]):
  - 0 DATA. Write pushes i_wdata[7:0]. Read returns 0.
  - 1 STATUS (read only). Bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[15:8] FIFO count. A read clears overflow.
  - 2 DIVISOR. Read/write, 16 bits.
  - 3 CONTROL. Read/write. Bit0 tx enable, bit1 empty-irq enable, bit2 parity enable (see optional feature).
- Bus handshake:
  - A request is accepted on a rising edge where (i_read|i_write)=1 and o_done=0.
  - o_done=1 for exactly the next cycle. o_rdata is valid in that same cycle and holds until the next accepted read.
  - A request still held while o_done=1 is ignored. If still held after that, it is accepted again, so each two-cycle hold produces one access.
  - i_read and i_write both high: treated as a write; o_rdata is unchanged.
- FIFO:
  - Circular buffer with pointers of width log2(FIFO_DEPTH) that wrap modulo the depth.
  - Write to DATA when full: byte dropped, overflow=1, o_done still pulses.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- Baud counter: loads DIVISOR at each bit start and counts down to 0. DIVISOR=0 gives 1 clock per bit. A new DIVISOR value takes effect at the next bit boundary.
- FSM states and transitions:
  - IDLE: o_txd=1. If enable=1 and the FIFO is not empty, pop one byte into the shift register and go to START.
  - START: o_txd=0 for one bit time, then go to DATA.
  - DATA: 8 bits, LSB first, one bit time each. Then go to PARITY if the optional feature is present and enabled, else STOP.
  - STOP: o_txd=1 for one bit time, then go to IDLE. Back-to-back frames leave no extra idle bit.
  - Clearing enable mid-frame: the current frame completes, then the FSM stays in IDLE.
- Interrupt: o_int = CONTROL.bit1 & FIFO empty & FSM==IDLE, registered (one cycle latency).
- First o_txd falling edge: two cycles after the o_done of the DATA write, when idle and enabled.

Optional Feature:
- Macro: MESM6_UART_TX_PARITY_EN.
- Defined: CONTROL bit2 is writable. When it is 1, an even-parity bit (XOR of the 8 data bits) is sent after the data bits for one bit time; the frame is 8E1.
- Undefined: CONTROL bit2 reads 0 and ignores writes; frames are always 8N1 and the PARITY state does not exist.

Test Plan:
- Reset, then read all four registers -> DATA=0, STATUS=0x0002, DIVISOR=86, CONTROL=0; o_txd=1, o_int=0.
- Write DIVISOR=3, CONTROL=1, DATA=0x55 -> on o_txd: start bit then 1,0,1,0,1,0,1,0, then stop; each bit exactly 4 clocks, 40 clocks in total.
- With enable=0, write 9 bytes (FIFO_DEPTH=8) -> STATUS reads full=1, overflow=1, count=8. Read STATUS again -> overflow=0. Set enable -> exactly 8 frames, back-to-back, no gap.
- CONTROL=3, write one byte 0xA5 -> o_int=0 during the frame; o_int rises one cycle after STOP ends; writing DATA drops o_int.
- Hold i_read high on STATUS for 6 cycles -> o_done pulses on cycles 2, 4, 6; assert reset mid-frame -> o_txd=1 the same cycle, FIFO empty after release.
- With MESM6_UART_TX_PARITY_EN defined, CONTROL=5, DIVISOR=0, byte 0x07 -> the parity bit after the data bits is 1 and the frame is 11 clocks; without the macro, CONTROL reads 1 and the frame is 10 clocks.
